// File: rtl/hilo_multiplier.sv
// Sequential 32-iteration shift-add multiplier with HI/LO result registers; DONE 32 edges after MUL load, commit on HILO_OPEN.
// No backpressure: any non-MUL funct aborts RUN, so the control unit must hold MUL. Define HILO_SIGNED_MUL_EN for signed operands.
module hilo_multiplier #(
  parameter int          WIDTH      = 32,
  parameter logic [5:0]  FUNCT_MUL  = 6'b011001,
  parameter logic [5:0]  FUNCT_MFHI = 6'b010000,
  parameter logic [5:0]  FUNCT_MFLO = 6'b010010,
  parameter logic [5:0]  HILO_OPEN  = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q, prod_hi_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q;

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] prod_d, result_d;
  logic [WIDTH-1:0]   opa_d, opb_d;

  // Carry out of the add is kept so it shifts into prod_hi's top bit.
  assign sum_d  = mplier_q[0] ? ({1'b0, prod_hi_q} + {1'b0, mcand_q}) : {1'b0, prod_hi_q};
  assign prod_d = {prod_hi_q, mplier_q};

`ifdef HILO_SIGNED_MUL_EN
  logic neg_q, neg_d;
  assign neg_d    = dataA[WIDTH-1] ^ dataB[WIDTH-1];
  assign opa_d    = dataA[WIDTH-1] ? -dataA : dataA;
  assign opb_d    = dataB[WIDTH-1] ? -dataB : dataB;
  assign result_d = neg_q ? -prod_d : prod_d;
`else
  assign opa_d    = dataA;
  assign opb_d    = dataB;
  assign result_d = prod_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_hi_q <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef HILO_SIGNED_MUL_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Signal == FUNCT_MUL) begin
            mcand_q   <= opa_d;
            mplier_q  <= opb_d;
            prod_hi_q <= '0;
            cnt_q     <= '0;
`ifdef HILO_SIGNED_MUL_EN
            neg_q     <= neg_d;
`endif
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
          end
        end
        S_RUN: begin
          if (Signal == FUNCT_MUL) begin
            prod_hi_q <= sum_d[WIDTH:1];
            mplier_q  <= {sum_d[0], mplier_q[WIDTH-1:1]};
            cnt_q     <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            // Abandoned multiply: HI/LO untouched.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          if (Signal == HILO_OPEN) begin
            hi_q    <= result_d[2*WIDTH-1:WIDTH];
            lo_q    <= result_d[WIDTH-1:0];
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else if (Signal != FUNCT_MUL) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dataOut = '0;
    if (Signal == FUNCT_MFHI)      dataOut = hi_q;
    else if (Signal == FUNCT_MFLO) dataOut = lo_q;
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
